card_shoe: RTL

Upstream card source for the baccarat datapath. It replaces the free-running rank counter with a finite shoe of `NUM_DECKS` × 52 cards, dealt without replacement. Each dealt rank comes from a pseudo-random scan of per-rank remaining-card counters. The datapath requests one card per load step and latches `deal_card` into the player or dealer card register selected by the active `load_*` strobe.

---
 rtl/card_shoe.sv | 106 ++++++++++
 1 files changed

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - finite multi-deck shoe dealing card ranks without replacement
// Optional CARD_SHOE_AUTO_SHUFFLE_EN: a request accepted while empty refills the shoe first.
module card_shoe #(
  parameter int unsigned NUM_DECKS = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       shuffle,
  input  logic       deal_req,
  output logic       ready,
  output logic       deal_valid,
  output logic [3:0] deal_card,
  output logic [8:0] cards_left,
  output logic       empty
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] SCAN      = 1'b1;
  localparam logic [5:0] RANK_FULL = 6'(4 * NUM_DECKS);
  localparam logic [8:0] SHOE_FULL = 9'(52 * NUM_DECKS);

  logic [0:0]  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [5:0]  cnt_q [1:13];
  logic [5:0]  cnt_d [1:13];
  logic [8:0]  left_q, left_d;
  logic        valid_q, valid_d;
  logic [3:0]  card_q, card_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        accept;
  logic [3:0]  start_ptr;

  assign empty = (left_q == 9'd0);
`ifdef CARD_SHOE_AUTO_SHUFFLE_EN
  assign ready = (state_q == IDLE);
`else
  assign ready = (state_q == IDLE) && !empty;
`endif
  assign accept    = deal_req && ready;
  assign start_ptr = (lfsr_q[3:0] % 4'd13) + 4'd1;
  // Free-running so that request timing perturbs which rank is picked.
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    valid_d = 1'b0;
    card_d  = card_q;
    if (shuffle) begin
      for (int r = 1; r <= 13; r++) cnt_d[r] = RANK_FULL;
      left_d  = SHOE_FULL;
      state_d = IDLE;
      card_d  = 4'd0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_d = SCAN;
        ptr_d   = start_ptr;
`ifdef CARD_SHOE_AUTO_SHUFFLE_EN
        if (empty) begin
          for (int r = 1; r <= 13; r++) cnt_d[r] = RANK_FULL;
          left_d = SHOE_FULL;
        end
`endif
      end
    end else begin
      // Walk ranks upward until one still has cards; shoe is non-empty here.
      if (cnt_q[ptr_q] != 6'd0) begin
        cnt_d[ptr_q] = cnt_q[ptr_q] - 6'd1;
        left_d       = left_q - 9'd1;
        card_d       = ptr_q;
        valid_d      = 1'b1;
        state_d      = IDLE;
      end else begin
        ptr_d = (ptr_q == 4'd13) ? 4'd1 : ptr_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= IDLE;
      ptr_q   <= 4'd1;
      for (int r = 1; r <= 13; r++) cnt_q[r] <= RANK_FULL;
      left_q  <= SHOE_FULL;
      valid_q <= 1'b0;
      card_q  <= 4'd0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      card_q  <= card_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign deal_valid = valid_q;
  assign deal_card  = card_q;
  assign cards_left = left_q;

endmodule
